// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared widths and the ID/EX stage record used by the
//                pipeline register and its hazard detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int REG_ADDR = 5;   // register address width
    localparam int WORD_W   = 32;  // data word width
    localparam int ALUOP_W  = 4;   // ALU operation code width

    // Everything the stage carries from ID into EX. An all-zero record is
    // a bubble: not valid, no side effects, no forwarding match.
    typedef struct packed {
        logic                valid;
        logic [REG_ADDR-1:0] src1;
        logic [REG_ADDR-1:0] src2;
        logic [REG_ADDR-1:0] dest_reg;
        logic                regwrite;
        logic                memread;
        logic                writemem;
        logic [ALUOP_W-1:0]  aluop;
        logic [WORD_W-1:0]   rs1_data;
        logic [WORD_W-1:0]   rs2_data;
        logic [WORD_W-1:0]   imm;
    } id_ex_t;

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detection between the load
//                sitting in ID/EX and the instruction currently in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_src1,
    input  logic [REG_ADDR-1:0] id_src2,
    input  logic                id_writemem,
    input  logic                ex_valid,
    input  logic                ex_memread,
    input  logic [REG_ADDR-1:0] ex_dest_reg,
    output logic                lu
);

    logic src1_match;
    logic src2_match;

    // A store's src2 is its data operand; the mem-to-mem bypass supplies it,
    // so only address (src1) dependencies of a store force a bubble.
    always_comb begin
        src1_match = (ex_dest_reg == id_src1);
        src2_match = (ex_dest_reg == id_src2) && !id_writemem;
        lu         = id_valid && ex_valid && ex_memread &&
                     (ex_dest_reg != '0) && (src1_match || src2_match);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use bubble insertion,
//                downstream stall hold, flush, and a saturating counter of
//                inserted load-use bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    id_valid,
    input  logic [REG_ADDR-1:0]     id_src1,
    input  logic [REG_ADDR-1:0]     id_src2,
    input  logic [REG_ADDR-1:0]     id_dest_reg,
    input  logic                    id_regwrite,
    input  logic                    id_memread,
    input  logic                    id_writemem,
    input  logic [ALUOP_W-1:0]      id_aluop,
    input  logic [WORD_W-1:0]       id_rs1_data,
    input  logic [WORD_W-1:0]       id_rs2_data,
    input  logic [WORD_W-1:0]       id_imm,

    input  logic                    ex_stall,
    input  logic                    flush,

    output logic                    id_ex_valid,
    output logic [REG_ADDR-1:0]     id_ex_src1,
    output logic [REG_ADDR-1:0]     id_ex_src2,
    output logic [REG_ADDR-1:0]     id_ex_dest_reg,
    output logic                    id_ex_regwrite,
    output logic                    id_ex_memread,
    output logic                    id_ex_writemem,
    output logic [ALUOP_W-1:0]      id_ex_aluop,
    output logic [WORD_W-1:0]       id_ex_rs1_data,
    output logic [WORD_W-1:0]       id_ex_rs2_data,
    output logic [WORD_W-1:0]       id_ex_imm,

    output logic                    id_stall,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    id_ex_t                  stage_q;
    id_ex_t                  stage_d;
    id_ex_t                  id_capture;
    logic [BUBBLE_CNT_W-1:0] bubble_count_q;
    logic [BUBBLE_CNT_W-1:0] bubble_count_d;
    logic                    lu;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_writemem (id_writemem),
        .ex_valid    (stage_q.valid),
        .ex_memread  (stage_q.memread),
        .ex_dest_reg (stage_q.dest_reg),
        .lu          (lu)
    );

    // Assemble the ID record; side-effect bits are killed for dead slots.
    always_comb begin
        id_capture          = '0;
        id_capture.valid    = id_valid;
        id_capture.src1     = id_src1;
        id_capture.src2     = id_src2;
        id_capture.dest_reg = id_dest_reg;
        id_capture.regwrite = id_regwrite & id_valid;
        id_capture.memread  = id_memread  & id_valid;
        id_capture.writemem = id_writemem & id_valid;
        id_capture.aluop    = id_aluop;
        id_capture.rs1_data = id_rs1_data;
        id_capture.rs2_data = id_rs2_data;
        id_capture.imm      = id_imm;
    end

    // Next stage contents: flush beats stall beats load-use beats capture.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (ex_stall) begin
            stage_d = stage_q;
        end else if (lu) begin
            stage_d = '0;
        end else begin
            stage_d = id_capture;
        end
    end

    // Count only bubbles that are actually inserted for a load-use hazard.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (!flush && !ex_stall && lu && (bubble_count_q != '1)) begin
            bubble_count_d = bubble_count_q + BUBBLE_CNT_W'(1);
        end
    end

    // IF/ID hold request; a flush clears IF/ID on its own path.
    always_comb begin
        id_stall = (ex_stall & ~flush) | (lu & ~flush);
    end

    // Pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Load-use bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    // Present the registered record on the flat output ports.
    always_comb begin
        id_ex_valid    = stage_q.valid;
        id_ex_src1     = stage_q.src1;
        id_ex_src2     = stage_q.src2;
        id_ex_dest_reg = stage_q.dest_reg;
        id_ex_regwrite = stage_q.regwrite;
        id_ex_memread  = stage_q.memread;
        id_ex_writemem = stage_q.writemem;
        id_ex_aluop    = stage_q.aluop;
        id_ex_rs1_data = stage_q.rs1_data;
        id_ex_rs2_data = stage_q.rs2_data;
        id_ex_imm      = stage_q.imm;
        bubble_count   = bubble_count_q;
    end

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage with an expected-value
//                queue fed at stimulus time and drained after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int CNT_W = 2;
    localparam int SW    = 1 + 5*3 + 3 + 4 + 32*3;   // flattened stage width

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_src1, id_src2, id_dest_reg;
    logic        id_regwrite, id_memread, id_writemem;
    logic [3:0]  id_aluop;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        ex_stall, flush;

    logic        id_ex_valid;
    logic [4:0]  id_ex_src1, id_ex_src2, id_ex_dest_reg;
    logic        id_ex_regwrite, id_ex_memread, id_ex_writemem;
    logic [3:0]  id_ex_aluop;
    logic [31:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic        id_stall;
    logic [CNT_W-1:0] bubble_count;

    id_ex_stage #(.BUBBLE_CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest_reg(id_dest_reg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_writemem(id_writemem),
        .id_aluop(id_aluop), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .ex_stall(ex_stall), .flush(flush),
        .id_ex_valid(id_ex_valid), .id_ex_src1(id_ex_src1),
        .id_ex_src2(id_ex_src2), .id_ex_dest_reg(id_ex_dest_reg),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .id_ex_writemem(id_ex_writemem), .id_ex_aluop(id_ex_aluop),
        .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_stall(id_stall),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0]    st;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    logic [SW-1:0]    m_st;    // reference stage contents
    logic [CNT_W-1:0] m_cnt;   // reference bubble count
    int               n_checks;
    int               n_errors;

    function automatic logic [SW-1:0] dut_stage();
        return {id_ex_valid, id_ex_src1, id_ex_src2, id_ex_dest_reg,
                id_ex_regwrite, id_ex_memread, id_ex_writemem, id_ex_aluop,
                id_ex_rs1_data, id_ex_rs2_data, id_ex_imm};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive, check id_stall against the reference, queue the
    // expected post-edge state, clock, then drain and compare.
    task automatic step(input string tag, input logic v, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d,
                        input logic rw, input logic mr, input logic wm,
                        input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic st, input logic fl, input int want_stall);
        logic       e_valid, e_mr;
        logic [4:0] e_dest;
        logic       lu, stall;
        exp_t       e, got;
        id_valid = v; id_src1 = s1; id_src2 = s2; id_dest_reg = d;
        id_regwrite = rw; id_memread = mr; id_writemem = wm; id_aluop = op;
        id_rs1_data = a; id_rs2_data = b; id_imm = im;
        ex_stall = st; flush = fl;
        #1;
        e_valid = m_st[SW-1];
        e_dest  = m_st[SW-12 -: 5];
        e_mr    = m_st[SW-18];
        lu = v && e_valid && e_mr && (e_dest != 5'd0) &&
             ((e_dest == s1) || ((e_dest == s2) && !wm));
        stall = !fl && (st || lu);
        check({tag, "_stall"}, 128'(id_stall), 128'(stall));
        if (want_stall >= 0)
            check({tag, "_stall_plan"}, 128'(id_stall), 128'(want_stall));
        if (fl)          m_st = '0;
        else if (st)     m_st = m_st;
        else if (lu) begin
            m_st = '0;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end else
            m_st = {v, s1, s2, d, rw & v, mr & v, wm & v, op, a, b, im};
        e.st = m_st; e.cnt = m_cnt; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(1), 128'(0));
        end else begin
            got = sb.pop_front();
            check({got.tag, "_stage"}, 128'(dut_stage()), 128'(got.st));
            check({got.tag, "_count"}, 128'(bubble_count), 128'(got.cnt));
        end
    endtask

    // Shorthand: load word into dest d (src1=1).
    task automatic lw(input string tag, input logic [4:0] d);
        step(tag, 1, 5'd1, 5'd0, d, 1, 1, 0, 4'h0, 32'h100, 32'h0, 32'h8, 0, 0, -1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_st = '0; m_cnt = '0;
        rst_n = 1'b0;
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_dest_reg = 0;
        id_regwrite = 0; id_memread = 0; id_writemem = 0; id_aluop = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        ex_stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stage", 128'(dut_stage()), 128'(0));
        check("reset_stall", 128'(id_stall), 128'(0));
        check("reset_count", 128'(bubble_count), 128'(0));
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use on src1: one bubble, then the add is captured.
        lw("lw_r3", 5'd3);
        check("lw_r3_memread", 128'(id_ex_memread), 128'(1));
        step("lu_bubble", 1, 5'd3, 5'd4, 5'd5, 1, 0, 0, 4'h2, 32'h11, 32'h22, 32'h0, 0, 0, 1);
        check("lu_bubble_valid", 128'(id_ex_valid), 128'(0));
        check("lu_bubble_dest", 128'(id_ex_dest_reg), 128'(0));
        check("lu_bubble_cnt", 128'(bubble_count), 128'(1));
        step("lu_add", 1, 5'd3, 5'd4, 5'd5, 1, 0, 0, 4'h2, 32'h11, 32'h22, 32'h0, 0, 0, 0);
        check("lu_add_dest", 128'(id_ex_dest_reg), 128'(5));

        // Store-data exemption, then store address dependency.
        lw("lw_r4a", 5'd4);
        step("sw_data", 1, 5'd2, 5'd4, 5'd4, 0, 0, 1, 4'h0, 32'h5, 32'h6, 32'h4, 0, 0, 0);
        check("sw_data_wm", 128'(id_ex_writemem), 128'(1));
        lw("lw_r4b", 5'd4);
        step("sw_addr", 1, 5'd4, 5'd7, 5'd7, 0, 0, 1, 4'h0, 32'h5, 32'h6, 32'h4, 0, 0, 1);
        step("sw_addr2", 1, 5'd4, 5'd7, 5'd7, 0, 0, 1, 4'h0, 32'h5, 32'h6, 32'h4, 0, 0, 0);

        // r0 destination and non-load producers never stall.
        lw("lw_r0", 5'd0);
        step("r0_use", 1, 5'd0, 5'd0, 5'd6, 1, 0, 0, 4'h1, 32'h1, 32'h2, 32'h3, 0, 0, 0);
        step("add_r3", 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 4'h1, 32'h1, 32'h2, 32'h3, 0, 0, -1);
        step("alu_use", 1, 5'd3, 5'd3, 5'd6, 1, 0, 0, 4'h1, 32'h1, 32'h2, 32'h3, 0, 0, 0);
        check("no_lu_cnt", 128'(bubble_count), 128'(2));

        // flush + ex_stall + load-use together: flush wins, no count.
        lw("lw_r3p", 5'd3);
        step("prio", 1, 5'd3, 5'd0, 5'd8, 1, 0, 0, 4'h3, 32'h9, 32'h9, 32'h9, 1, 1, 0);
        check("prio_valid", 128'(id_ex_valid), 128'(0));
        check("prio_cnt", 128'(bubble_count), 128'(2));

        // ex_stall alone for 3 cycles freezes the stage.
        lw("lw_r9", 5'd9);
        for (int i = 0; i < 3; i++)
            step($sformatf("frz%0d", i), 1, 5'd9, 5'd10, 5'd11, 1, 0, 0, 4'h4,
                 32'hA0 + 32'(i), 32'hB0, 32'hC0, 1, 0, 1);
        check("frz_dest", 128'(id_ex_dest_reg), 128'(9));

        // Dead slot: fields load, side-effect bits gated.
        step("dead", 0, 5'd12, 5'd13, 5'd14, 1, 1, 1, 4'h7, 32'hDEAD, 32'hBEEF, 32'h1, 0, 0, 0);
        check("dead_rw", 128'({id_ex_regwrite, id_ex_memread, id_ex_writemem}), 128'(0));
        check("dead_dest", 128'(id_ex_dest_reg), 128'(14));

        // Saturation: repeated load-use pairs.
        for (int i = 0; i < 5; i++) begin
            lw($sformatf("sat_lw%0d", i), 5'd3);
            step($sformatf("sat_b%0d", i), 1, 5'd3, 5'd0, 5'd5, 1, 0, 0, 4'h2,
                 32'h1, 32'h2, 32'h3, 0, 0, 1);
        end
        check("sat_cnt", 128'(bubble_count), 128'(3));

        // Random traffic on a small register set.
        for (int i = 0; i < 300; i++)
            step("rnd", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0), -1);

        // Asynchronous reset mid-stream.
        step("pre_rst", 1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 4'h1, 32'h7, 32'h8, 32'h9, 0, 0, 0);
        check("pre_rst_valid", 128'(id_ex_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_stage", 128'(dut_stage()), 128'(0));
        check("arst_count", 128'(bubble_count), 128'(0));
        check("arst_stall", 128'(id_stall), 128'(0));
        m_st = '0; m_cnt = '0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
